// File: rtl/id_redirect_ctrl_if.sv
// Bundle of IF/ID pipeline, hazard and fetch-redirect signals between the
// decode controller and its pipeline neighbours.
interface id_redirect_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          Instruction_if;
  logic [31:0]          NextPC_if;
  logic [31:0]          rs_data_id;
  logic [31:0]          rt_data_id;
  logic                 MemRead_ex;
  logic                 RegWrite_ex;
  logic [4:0]           WriteReg_ex;
  logic                 MemRead_mem;
  logic [4:0]           WriteReg_mem;

  logic [31:0]          Instruction_id;
  logic [31:0]          NextPC_id;
  logic                 Z;
  logic                 J;
  logic                 JR;
  logic [31:0]          JumpAddr;
  logic [31:0]          BranchAddr;
  logic [31:0]          JrAddr;
  logic                 PC_IFWrite;
  logic                 ID_bubble;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output Instruction_if, NextPC_if, rs_data_id, rt_data_id,
           MemRead_ex, RegWrite_ex, WriteReg_ex, MemRead_mem, WriteReg_mem,
    input  Instruction_id, NextPC_id, Z, J, JR, JumpAddr, BranchAddr, JrAddr,
           PC_IFWrite, ID_bubble, stall_count, flush_count
  );

  modport slave (
    input  Instruction_if, NextPC_if, rs_data_id, rt_data_id,
           MemRead_ex, RegWrite_ex, WriteReg_ex, MemRead_mem, WriteReg_mem,
    output Instruction_id, NextPC_id, Z, J, JR, JumpAddr, BranchAddr, JrAddr,
           PC_IFWrite, ID_bubble, stall_count, flush_count
  );
endinterface

// File: rtl/id_redirect_ctrl.sv
// ID-stage controller: IF/ID register, branch/jump resolution, hazard stalls,
// wrong-path squash and saturating stall/flush event counters.
module id_redirect_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  id_redirect_ctrl_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0]          r_instructionId;
  logic [31:0]          r_nextPcId;
  logic [CNT_WIDTH-1:0] r_stallCount;
  logic [CNT_WIDTH-1:0] r_flushCount;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rsId;
  logic [4:0]  w_rtId;
  logic        w_isRtype;
  logic        w_isJump;
  logic        w_isBeq;
  logic        w_isBne;
  logic        w_isBranch;
  logic        w_isJr;
  logic        w_usesRt;
  logic        w_exHitsRs;
  logic        w_exHitsRt;
  logic        w_memHitsRs;
  logic        w_memHitsRt;
  logic        w_loadUse;
  logic        w_brHazard;
  logic        w_stall;
  logic        w_taken;
  logic        w_z;
  logic        w_j;
  logic        w_jr;
  logic        w_redirect;
  logic [31:0] w_branchOffset;

  assign w_opcode   = r_instructionId[31:26];
  assign w_funct    = r_instructionId[5:0];
  assign w_rsId     = r_instructionId[25:21];
  assign w_rtId     = r_instructionId[20:16];

  assign w_isRtype  = (w_opcode == OP_RTYPE);
  assign w_isJump   = (w_opcode == OP_J) || (w_opcode == OP_JAL);
  assign w_isBeq    = (w_opcode == OP_BEQ);
  assign w_isBne    = (w_opcode == OP_BNE);
  assign w_isBranch = w_isBeq || w_isBne;
  assign w_isJr     = w_isRtype && (w_funct == FN_JR);
  assign w_usesRt   = w_isRtype || w_isBranch;

  // Register $0 is hard-wired, so a write to it never creates a dependence.
  assign w_exHitsRs  = (w_rsId != 5'd0) && (w_rsId == bus.WriteReg_ex);
  assign w_exHitsRt  = (w_rtId != 5'd0) && (w_rtId == bus.WriteReg_ex);
  assign w_memHitsRs = (w_rsId != 5'd0) && (w_rsId == bus.WriteReg_mem);
  assign w_memHitsRt = (w_rtId != 5'd0) && (w_rtId == bus.WriteReg_mem);

  assign w_loadUse  = bus.MemRead_ex && (w_exHitsRs || (w_usesRt && w_exHitsRt));

  // Branches resolve in ID, so operands still in flight from EX or a load in MEM must wait.
  assign w_brHazard = (w_isBranch || w_isJr) &&
                      ((bus.RegWrite_ex && w_exHitsRs) || (bus.MemRead_mem && w_memHitsRs) ||
                       (w_isBranch && ((bus.RegWrite_ex && w_exHitsRt) ||
                                       (bus.MemRead_mem && w_memHitsRt))));

  assign w_stall    = w_loadUse || w_brHazard;

  assign w_taken    = (w_isBeq && (bus.rs_data_id == bus.rt_data_id)) ||
                      (w_isBne && (bus.rs_data_id != bus.rt_data_id));
  assign w_z        = w_taken  && !w_stall;
  assign w_j        = w_isJump && !w_stall;
  assign w_jr       = w_isJr   && !w_stall;
  assign w_redirect = w_z || w_j || w_jr;

  assign w_branchOffset = {{14{r_instructionId[15]}}, r_instructionId[15:0], 2'b00};

  assign bus.Instruction_id = r_instructionId;
  assign bus.NextPC_id      = r_nextPcId;
  assign bus.Z              = w_z;
  assign bus.J              = w_j;
  assign bus.JR             = w_jr;
  assign bus.JumpAddr       = {r_nextPcId[31:28], r_instructionId[25:0], 2'b00};
  assign bus.BranchAddr     = r_nextPcId + w_branchOffset;
  assign bus.JrAddr         = bus.rs_data_id;
  assign bus.PC_IFWrite     = !w_stall;
  assign bus.ID_bubble      = w_stall;
  assign bus.stall_count    = r_stallCount;
  assign bus.flush_count    = r_flushCount;

  // A redirect replaces the already-fetched wrong-path instruction with a nop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instructionId <= '0;
      r_nextPcId      <= '0;
      r_stallCount    <= '0;
      r_flushCount    <= '0;
    end else begin
      if (!w_stall) begin
        r_instructionId <= w_redirect ? 32'd0 : bus.Instruction_if;
        r_nextPcId      <= bus.NextPC_if;
      end
      if (w_stall && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + CNT_WIDTH'(1);
      end
      if (w_redirect && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_redirect_ctrl.sv
// Self-checking bench for id_redirect_ctrl: directed scenarios plus a randomized
// run against a behavioural reference model; a 2-bit-counter copy checks saturation.
module tb_id_redirect_ctrl;

  logic clk;
  logic reset;

  id_redirect_ctrl_if #(.CNT_WIDTH(16)) bus ();
  id_redirect_ctrl_if #(.CNT_WIDTH(2))  busSat ();

  id_redirect_ctrl #(.CNT_WIDTH(16)) dut    (.clk(clk), .reset(reset), .bus(bus.slave));
  id_redirect_ctrl #(.CNT_WIDTH(2))  dutSat (.clk(clk), .reset(reset), .bus(busSat.slave));

  assign busSat.Instruction_if = bus.Instruction_if;
  assign busSat.NextPC_if      = bus.NextPC_if;
  assign busSat.rs_data_id     = bus.rs_data_id;
  assign busSat.rt_data_id     = bus.rt_data_id;
  assign busSat.MemRead_ex     = bus.MemRead_ex;
  assign busSat.RegWrite_ex    = bus.RegWrite_ex;
  assign busSat.WriteReg_ex    = bus.WriteReg_ex;
  assign busSat.MemRead_mem    = bus.MemRead_mem;
  assign busSat.WriteReg_mem   = bus.WriteReg_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_OTHER, K_J, K_JAL, K_BEQ, K_BNE, K_JR} kindT;

  typedef struct packed {
    logic        z;
    logic        j;
    logic        jr;
    logic        stall;
    logic [31:0] jumpAddr;
    logic [31:0] branchAddr;
  } evalT;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [31:0] mInstr = 32'd0;
  logic [31:0] mNpc   = 32'd0;
  int          mStall = 0;
  int          mFlush = 0;

  function automatic kindT classify(input logic [31:0] ins);
    case (ins[31:26])
      6'd2:    return K_J;
      6'd3:    return K_JAL;
      6'd4:    return K_BEQ;
      6'd5:    return K_BNE;
      6'd0:    return (ins[5:0] == 6'd8) ? K_JR : K_OTHER;
      default: return K_OTHER;
    endcase
  endfunction

  function automatic bit dependsOn(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic evalT modelEval(input logic [31:0] ins, input logic [31:0] npc);
    evalT e;
    kindT k;
    logic [4:0] rs, rt;
    bit usesRt, isBr, loadUse, brHaz, taken;
    int offset;
    k      = classify(ins);
    rs     = ins[25:21];
    rt     = ins[20:16];
    isBr   = (k == K_BEQ) || (k == K_BNE);
    usesRt = (ins[31:26] == 6'd0) || isBr;
    loadUse = bus.MemRead_ex &&
              (dependsOn(rs, bus.WriteReg_ex) || (usesRt && dependsOn(rt, bus.WriteReg_ex)));
    brHaz = 1'b0;
    if (isBr || k == K_JR) begin
      if (bus.RegWrite_ex && dependsOn(rs, bus.WriteReg_ex)) brHaz = 1'b1;
      if (bus.MemRead_mem && dependsOn(rs, bus.WriteReg_mem)) brHaz = 1'b1;
      if (isBr && bus.RegWrite_ex && dependsOn(rt, bus.WriteReg_ex)) brHaz = 1'b1;
      if (isBr && bus.MemRead_mem && dependsOn(rt, bus.WriteReg_mem)) brHaz = 1'b1;
    end
    taken = (k == K_BEQ && bus.rs_data_id == bus.rt_data_id) ||
            (k == K_BNE && bus.rs_data_id != bus.rt_data_id);
    e.stall      = loadUse || brHaz;
    e.z          = taken && !e.stall;
    e.j          = (k == K_J || k == K_JAL) && !e.stall;
    e.jr         = (k == K_JR) && !e.stall;
    e.jumpAddr   = {npc[31:28], ins[25:0], 2'b00};
    offset       = int'($signed(ins[15:0])) * 4;
    e.branchAddr = npc + 32'(offset);
    return e;
  endfunction

  // Advance the reference model by one edge using the inputs present at that edge.
  task automatic tick();
    evalT e;
    e = modelEval(mInstr, mNpc);
    if (!reset) begin
      mInstr = 32'd0; mNpc = 32'd0; mStall = 0; mFlush = 0;
    end else if (e.stall) begin
      mStall++;
    end else if (e.z || e.j || e.jr) begin
      mFlush++; mInstr = 32'd0; mNpc = bus.NextPC_if;
    end else begin
      mInstr = bus.Instruction_if; mNpc = bus.NextPC_if;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.MemRead_ex = 1'b0; bus.RegWrite_ex = 1'b0; bus.WriteReg_ex = 5'd0;
    bus.MemRead_mem = 1'b0; bus.WriteReg_mem = 5'd0;
    bus.rs_data_id = 32'd0; bus.rt_data_id = 32'd0;
  endtask

  task automatic loadId(input logic [31:0] ins, input logic [31:0] npc);
    quiet();
    bus.Instruction_if = 32'd0; bus.NextPC_if = 32'd0;
    tick();
    bus.Instruction_if = ins; bus.NextPC_if = npc;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    quiet();
    bus.Instruction_if = 32'h08000010; bus.NextPC_if = 32'h00000004;
    tick(); tick();
    #2;
    nVectors++; if (bus.Instruction_id !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_instr: got %h expected %h", bus.Instruction_id, 32'd0); end
    nVectors++; if (bus.NextPC_id !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_npc: got %h expected %h", bus.NextPC_id, 32'd0); end
    nVectors++; if ({bus.Z, bus.J, bus.JR} !== 3'b000) begin nMiscompares++; $display("[TB] FAIL reset_redirect: got %b expected 000", {bus.Z, bus.J, bus.JR}); end
    nVectors++; if (bus.PC_IFWrite !== 1'b1 || bus.ID_bubble !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_stall: got pcw=%b bub=%b expected pcw=1 bub=0", bus.PC_IFWrite, bus.ID_bubble); end
    nVectors++; if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", bus.stall_count, bus.flush_count); end
    nVectors++; if (bus.JumpAddr !== 32'd0 || bus.BranchAddr !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_addr: got %h/%h expected 0/0", bus.JumpAddr, bus.BranchAddr); end
    reset = 1'b1;
  endtask

  task automatic test_jump();
    loadId(32'h08000010, 32'h00400008);
    bus.Instruction_if = 32'h20080005; bus.NextPC_if = 32'h0040000C;
    #2;
    nVectors++; if ({bus.Z, bus.J, bus.JR} !== 3'b010) begin nMiscompares++; $display("[TB] FAIL jump_j: got %b expected 010", {bus.Z, bus.J, bus.JR}); end
    nVectors++; if (bus.JumpAddr !== 32'h00000040) begin nMiscompares++; $display("[TB] FAIL jump_addr: got %h expected %h", bus.JumpAddr, 32'h00000040); end
    tick();
    nVectors++; if (bus.Instruction_id !== 32'd0) begin nMiscompares++; $display("[TB] FAIL jump_squash: got %h expected %h", bus.Instruction_id, 32'd0); end
    nVectors++; if (bus.NextPC_id !== 32'h0040000C) begin nMiscompares++; $display("[TB] FAIL jump_npc: got %h expected %h", bus.NextPC_id, 32'h0040000C); end
    nVectors++; if (bus.flush_count !== 16'd1) begin nMiscompares++; $display("[TB] FAIL jump_flush: got %0d expected 1", bus.flush_count); end
  endtask

  task automatic test_beq();
    int flushBefore;
    loadId(32'h1022FFFD, 32'h00000014);
    bus.rs_data_id = 32'd5; bus.rt_data_id = 32'd5;
    #2;
    nVectors++; if (bus.Z !== 1'b1 || bus.BranchAddr !== 32'h00000008) begin nMiscompares++; $display("[TB] FAIL beq_taken: got z=%b addr=%h expected z=1 addr=00000008", bus.Z, bus.BranchAddr); end
    bus.rt_data_id = 32'd6;
    bus.Instruction_if = 32'h20080001; bus.NextPC_if = 32'h00000018;
    flushBefore = mFlush;
    #2;
    nVectors++; if (bus.Z !== 1'b0) begin nMiscompares++; $display("[TB] FAIL beq_not_taken: got %b expected 0", bus.Z); end
    tick();
    nVectors++; if (bus.Instruction_id !== 32'h20080001 || bus.flush_count !== 16'(flushBefore)) begin nMiscompares++; $display("[TB] FAIL beq_fallthrough: got %h/%0d expected 20080001/%0d", bus.Instruction_id, bus.flush_count, flushBefore); end
    loadId(32'h1400FFFF, 32'h00000000);
    bus.rs_data_id = 32'd1;
    #2;
    nVectors++; if (bus.Z !== 1'b1 || bus.BranchAddr !== 32'hFFFFFFFC) begin nMiscompares++; $display("[TB] FAIL bne_self: got z=%b addr=%h expected z=1 addr=fffffffc", bus.Z, bus.BranchAddr); end
    tick();
  endtask

  task automatic test_load_use();
    loadId(32'h010A4820, 32'h00000100);
    bus.MemRead_ex = 1'b1; bus.WriteReg_ex = 5'd8;
    bus.Instruction_if = 32'h20090002; bus.NextPC_if = 32'h00000104;
    #2;
    nVectors++; if (bus.PC_IFWrite !== 1'b0 || bus.ID_bubble !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lu_stall: got pcw=%b bub=%b expected pcw=0 bub=1", bus.PC_IFWrite, bus.ID_bubble); end
    tick();
    nVectors++; if (bus.Instruction_id !== 32'h010A4820 || bus.stall_count !== 16'(mStall)) begin nMiscompares++; $display("[TB] FAIL lu_hold: got %h/%0d expected 010a4820/%0d", bus.Instruction_id, bus.stall_count, mStall); end
    bus.WriteReg_ex = 5'd10;
    #2;
    nVectors++; if (bus.PC_IFWrite !== 1'b0) begin nMiscompares++; $display("[TB] FAIL lu_rt: got %b expected 0", bus.PC_IFWrite); end
    bus.MemRead_ex = 1'b0;
    #2;
    nVectors++; if (bus.PC_IFWrite !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lu_clear: got %b expected 1", bus.PC_IFWrite); end
    tick();
    nVectors++; if (bus.Instruction_id !== 32'h20090002) begin nMiscompares++; $display("[TB] FAIL lu_proceed: got %h expected %h", bus.Instruction_id, 32'h20090002); end
    bus.MemRead_ex = 1'b1; bus.WriteReg_ex = 5'd9;
    #2;
    nVectors++; if (bus.PC_IFWrite !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lu_itype_rt: got %b expected 1", bus.PC_IFWrite); end
    loadId(32'h00004820, 32'h00000200);
    bus.MemRead_ex = 1'b1; bus.WriteReg_ex = 5'd0;
    #2;
    nVectors++; if (bus.PC_IFWrite !== 1'b1) begin nMiscompares++; $display("[TB] FAIL lu_reg0: got %b expected 1", bus.PC_IFWrite); end
    quiet();
  endtask

  task automatic test_jr_hazard();
    loadId(32'h03E00008, 32'h00400020);
    bus.RegWrite_ex = 1'b1; bus.WriteReg_ex = 5'd31; bus.rs_data_id = 32'h00400100;
    #2;
    nVectors++; if (bus.JR !== 1'b0 || bus.PC_IFWrite !== 1'b0) begin nMiscompares++; $display("[TB] FAIL jr_stall: got jr=%b pcw=%b expected jr=0 pcw=0", bus.JR, bus.PC_IFWrite); end
    tick();
    bus.RegWrite_ex = 1'b0; bus.MemRead_mem = 1'b1; bus.WriteReg_mem = 5'd31;
    #2;
    nVectors++; if (bus.JR !== 1'b0 || bus.ID_bubble !== 1'b1) begin nMiscompares++; $display("[TB] FAIL jr_mem_haz: got jr=%b bub=%b expected jr=0 bub=1", bus.JR, bus.ID_bubble); end
    tick();
    bus.MemRead_mem = 1'b0;
    #2;
    nVectors++; if (bus.JR !== 1'b1 || bus.JrAddr !== 32'h00400100) begin nMiscompares++; $display("[TB] FAIL jr_go: got jr=%b addr=%h expected jr=1 addr=00400100", bus.JR, bus.JrAddr); end
    tick();
    quiet();
  endtask

  task automatic test_saturation_reset();
    reset = 1'b0; quiet(); tick(); reset = 1'b1;
    loadId(32'h010A4820, 32'h00000300);
    bus.MemRead_ex = 1'b1; bus.WriteReg_ex = 5'd8;
    tick(); tick();
    nVectors++; if (busSat.stall_count !== 2'd2) begin nMiscompares++; $display("[TB] FAIL sat_two: got %0d expected 2", busSat.stall_count); end
    tick(); tick(); tick();
    nVectors++; if (busSat.stall_count !== 2'd3 || bus.stall_count !== 16'd5) begin nMiscompares++; $display("[TB] FAIL sat_hold: got %0d/%0d expected 3/5", busSat.stall_count, bus.stall_count); end
    reset = 1'b0;
    tick();
    #2;
    nVectors++; if (bus.Instruction_id !== 32'd0 || bus.PC_IFWrite !== 1'b1 || bus.stall_count !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_mid_stall: got %h pcw=%b cnt=%0d expected 0 pcw=1 cnt=0", bus.Instruction_id, bus.PC_IFWrite, bus.stall_count); end
    reset = 1'b1;
    quiet();
  endtask

  task automatic test_random();
    evalT e;
    logic [4:0] rs, rt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 39) != 0);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: bus.Instruction_if = {6'd2, 26'($urandom)};
        1: bus.Instruction_if = {6'd3, 26'($urandom)};
        2: bus.Instruction_if = {6'd4, rs, rt, 16'($urandom)};
        3: bus.Instruction_if = {6'd5, rs, rt, 16'($urandom)};
        4: bus.Instruction_if = {6'd0, rs, 15'd0, 6'd8};
        5: bus.Instruction_if = {6'd0, rs, rt, 5'd9, 5'd0, 6'd32};
        6: bus.Instruction_if = {6'd8, rs, rt, 16'($urandom)};
        default: bus.Instruction_if = $urandom;
      endcase
      bus.NextPC_if    = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      bus.rs_data_id   = 32'($urandom_range(0, 2));
      bus.rt_data_id   = 32'($urandom_range(0, 2));
      bus.MemRead_ex   = ($urandom_range(0, 3) == 0);
      bus.RegWrite_ex  = ($urandom_range(0, 3) == 0);
      bus.WriteReg_ex  = 5'($urandom_range(0, 3));
      bus.MemRead_mem  = ($urandom_range(0, 3) == 0);
      bus.WriteReg_mem = 5'($urandom_range(0, 3));
      #2;
      e = modelEval(mInstr, mNpc);
      nVectors++; if (bus.Instruction_id !== mInstr || bus.NextPC_id !== mNpc) begin nMiscompares++; $display("[TB] FAIL rnd_ifid c%0d: got %h/%h expected %h/%h", cyc, bus.Instruction_id, bus.NextPC_id, mInstr, mNpc); end
      nVectors++; if ({bus.Z, bus.J, bus.JR} !== {e.z, e.j, e.jr}) begin nMiscompares++; $display("[TB] FAIL rnd_redirect c%0d: got %b expected %b", cyc, {bus.Z, bus.J, bus.JR}, {e.z, e.j, e.jr}); end
      nVectors++; if (bus.PC_IFWrite !== !e.stall || bus.ID_bubble !== e.stall) begin nMiscompares++; $display("[TB] FAIL rnd_stall c%0d: got pcw=%b bub=%b expected stall=%b", cyc, bus.PC_IFWrite, bus.ID_bubble, e.stall); end
      nVectors++; if (bus.JumpAddr !== e.jumpAddr || bus.BranchAddr !== e.branchAddr || bus.JrAddr !== bus.rs_data_id) begin nMiscompares++; $display("[TB] FAIL rnd_addr c%0d: got %h/%h/%h expected %h/%h/%h", cyc, bus.JumpAddr, bus.BranchAddr, bus.JrAddr, e.jumpAddr, e.branchAddr, bus.rs_data_id); end
      nVectors++; if (bus.stall_count !== 16'(mStall) || bus.flush_count !== 16'(mFlush)) begin nMiscompares++; $display("[TB] FAIL rnd_counts c%0d: got %0d/%0d expected %0d/%0d", cyc, bus.stall_count, bus.flush_count, mStall, mFlush); end
      nVectors++; if (busSat.stall_count !== 2'((mStall > 3) ? 3 : mStall) || busSat.flush_count !== 2'((mFlush > 3) ? 3 : mFlush)) begin nMiscompares++; $display("[TB] FAIL rnd_sat c%0d: got %0d/%0d expected %0d/%0d", cyc, busSat.stall_count, busSat.flush_count, (mStall > 3) ? 3 : mStall, (mFlush > 3) ? 3 : mFlush); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.Instruction_if = 32'd0;
    bus.NextPC_if = 32'd0;
    quiet();
    test_reset();
    test_jump();
    test_beq();
    test_load_use();
    test_jr_hazard();
    test_saturation_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/id_redirect_ctrl.md
Name: id_redirect_ctrl

Overview:
- Decode-side partner of the instruction fetch stage in the 5-stage MIPS pipeline.
- Holds the IF/ID pipeline register and resolves beq/bne/j/jal/jr in ID.
- Drives the fetch-redirect inputs Z, J, JR, JumpAddr, BranchAddr, JrAddr, and the fetch hold PC_IFWrite.
- Detects load-use and branch-operand hazards, squashes wrong-path fetches, and keeps stall/flush event counters.

Parameters:
CNT_WIDTH, 16, width of the stall and flush event counters (saturating).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
Instruction_if  input  32  instruction from fetch stage
NextPC_if  input  32  PC+4 from fetch stage
rs_data_id  input  32  rs operand for the ID instruction, already forwarded
rt_data_id  input  32  rt operand for the ID instruction, already forwarded
MemRead_ex  input  1  EX-stage instruction is a load
RegWrite_ex  input  1  EX-stage instruction writes a register
WriteReg_ex  input  5  EX-stage destination register
MemRead_mem  input  1  MEM-stage instruction is a load
WriteReg_mem  input  5  MEM-stage destination register
Instruction_id  output  32  IF/ID instruction
NextPC_id  output  32  IF/ID PC+4
Z  output  1  branch taken, redirect to BranchAddr
J  output  1  jump (j/jal), redirect to JumpAddr
JR  output  1  jump register, redirect to JrAddr
JumpAddr  output  32  {NextPC_id[31:28], Instruction_id[25:0], 2'b00}
BranchAddr  output  32  NextPC_id + (signext(Instruction_id[15:0]) << 2)
JrAddr  output  32  rs_data_id
PC_IFWrite  output  1  1 = fetch PC may advance; 0 = hold
ID_bubble  output  1  1 = drive all-zero control into ID/EX this cycle
stall_count  output  CNT_WIDTH  cycles with PC_IFWrite=0
flush_count  output  CNT_WIDTH  wrong-path fetches squashed

Behaviour:
- Opcode decode on Instruction_id[31:26]:
  - 000010 = j; 000011 = jal; 000100 = beq; 000101 = bne.
  - 000000 with funct[5:0] = 001000 = jr.
  - All other encodings are non-control; they never redirect.
- rs_id = Instruction_id[25:21]; rt_id = Instruction_id[20:16].
- uses_rt is 1 for R-type, beq, bne.
- Hazards are checked only when the register number is non-zero.
- load_use = MemRead_ex && (WriteReg_ex==rs_id || (uses_rt && WriteReg_ex==rt_id)).
- br_hazard applies only to beq/bne/jr. It is true when either condition holds on rs_id, or rt_id for beq/bne:
  - RegWrite_ex && WriteReg_ex matches the register;
  - MemRead_mem && WriteReg_mem matches the register.
- stall = load_use || br_hazard.
  - PC_IFWrite = !stall.
  - ID_bubble = stall.
- Redirects:
  - Raw conditions: taken = (beq && rs_data_id==rt_data_id) || (bne && rs_data_id!=rt_data_id).
  - Z = taken && !stall.
  - J = (j||jal) && !stall.
  - JR = jr && !stall.
  - At most one of Z/J/JR is ever 1; the fetch mux treats any other combination as PC+4.
- Z, J, JR, PC_IFWrite, ID_bubble and the address outputs are combinational from the IF/ID register and the inputs. The register-to-output path has no added latency.
- IF/ID update, priority order at each rising edge:
  1. reset==0: Instruction_id=0 (nop), NextPC_id=0, both counters=0.
  2. stall: hold Instruction_id and NextPC_id.
  3. Z|J|JR: load nop (0) into Instruction_id; NextPC_id <= NextPC_if. This squashes the wrong-path fetch; there is no delay slot.
  4. Otherwise: load Instruction_if and NextPC_if.
- Counters:
  - stall_count increments each non-reset cycle with stall=1.
  - flush_count increments each non-reset cycle with Z|J|JR=1.
  - Both saturate at all-ones and do not wrap.
- Reset values: Instruction_id=0, NextPC_id=0, Z=J=JR=0, PC_IFWrite=1, ID_bubble=0, JumpAddr=0, BranchAddr=0, counters=0. JrAddr follows rs_data_id.
- Reset asserted mid-stall or mid-flush wins: pending stall/redirect is discarded and the IF/ID register is cleared on that edge.
- Stall and redirect in the same cycle: stall wins. Redirect outputs are masked and re-evaluate once the hazard clears.
- Branch to self (imm = 0xFFFF): BranchAddr = NextPC_id - 4. Arithmetic is modulo 2^32.

Test Plan:
- Reset: hold reset=0 for 2 clk with Instruction_if=0x08000010 -> Instruction_id=0, Z=J=JR=0, PC_IFWrite=1, counters=0.
- Jump: IF/ID holds j 0x0000010 with NextPC_id=0x00400008 -> J=1, JumpAddr=0x00000040; next edge Instruction_id=0, flush_count=1.
- beq equal: NextPC_id=0x00000014, imm=0xFFFD, rs_data=rt_data=5 -> Z=1, BranchAddr=0x00000008. Same with rt_data=6 -> Z=0, no flush.
- Load-use: MemRead_ex=1, WriteReg_ex=8, ID holds add $9,$8,$10 -> PC_IFWrite=0, ID_bubble=1, IF/ID held one cycle, stall_count=1. Next cycle, with MemRead_ex=0, proceed.
- jr hazard: RegWrite_ex=1, WriteReg_ex=31, ID holds jr $31, rs_data=0x00400100 -> JR=0 and stall for that cycle. Next cycle, with the hazard cleared, JR=1, JrAddr=0x00400100.
- Saturation and reset mid-stall: CNT_WIDTH=2, 5 stall cycles -> stall_count=3. Assert reset during a stall -> IF/ID=0 and PC_IFWrite=1 after that edge.
